// File: rtl/pic_sequencer.sv
// ---------------------------------------------------------------------------
// pic_sequencer
//
// Sequencing controller for the parallel indices comparison datapath. Walks
// two sorted sparse-vector index lists held in synchronous index memories and
// performs a merge-style intersection, one comparison every two cycles
// (FETCH then CMP). Every index found in both lists is written into the match
// FIFO together with its positions in list A and list B. FIFO back-pressure
// holds the sequencer in CMP with stable memory data until the write is taken.
//
// Ports
//   clk, rst_n            : clock (rising edge), async active-low reset
//   start                 : begin a run; only sampled in IDLE
//   len_a, len_b          : list lengths, latched when start is accepted
//   a_rd, a_addr, a_idx   : index memory A read strobe / address / data
//                           (data valid the cycle after a_rd, held after)
//   b_rd, b_addr, b_idx   : same for index memory B
//   fifo_full             : match FIFO cannot take a write this cycle
//   match_wr              : match FIFO write strobe
//   match_idx             : matched index value (0 when match_wr is low)
//   match_a_pos/_b_pos    : positions of the match in A / B (0 when idle)
//   busy                  : high in FETCH and CMP
//   done                  : one-cycle completion pulse
//   match_count           : matches written in the current or last run
// ---------------------------------------------------------------------------
module pic_sequencer #(
    parameter int IDX_W  = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   len_a,
    input  logic [ADDR_W:0]   len_b,
    output logic              a_rd,
    output logic [ADDR_W-1:0] a_addr,
    input  logic [IDX_W-1:0]  a_idx,
    output logic              b_rd,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [IDX_W-1:0]  b_idx,
    input  logic              fifo_full,
    output logic              match_wr,
    output logic [IDX_W-1:0]  match_idx,
    output logic [ADDR_W-1:0] match_a_pos,
    output logic [ADDR_W-1:0] match_b_pos,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   match_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_CMP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   PTR_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [IDX_W-1:0]  IDX_ZERO  = {IDX_W{1'b0}};

    state_t          state_r;
    logic [ADDR_W:0] pa_r;
    logic [ADDR_W:0] pb_r;
    logic [ADDR_W:0] la_r;
    logic [ADDR_W:0] lb_r;
    logic [ADDR_W:0] match_count_r;

    logic            idx_lt_s;
    logic            idx_gt_s;
    logic            idx_eq_s;
    logic [ADDR_W:0] pa_inc_s;
    logic [ADDR_W:0] pb_inc_s;
    logic            a_last_s;
    logic            b_last_s;
    logic            len_zero_s;
    logic            match_fire_s;

    // Compare decode and end-of-list detection for the current CMP cycle.
    // The "last" flags look at the incremented pointer so the run ends on the
    // same edge that consumes the final entry; no read past a list is issued.
    always_comb begin
        idx_lt_s   = (a_idx < b_idx);
        idx_gt_s   = (a_idx > b_idx);
        idx_eq_s   = (a_idx == b_idx);
        pa_inc_s   = pa_r + PTR_ONE;
        pb_inc_s   = pb_r + PTR_ONE;
        a_last_s   = (pa_inc_s == la_r);
        b_last_s   = (pb_inc_s == lb_r);
        len_zero_s = (len_a == PTR_ZERO) || (len_b == PTR_ZERO);
        if (state_r == ST_CMP) begin
            match_fire_s = idx_eq_s && !fifo_full;
        end else begin
            match_fire_s = 1'b0;
        end
    end

    // Sequencer FSM with list pointers, latched lengths and match counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            pa_r          <= PTR_ZERO;
            pb_r          <= PTR_ZERO;
            la_r          <= PTR_ZERO;
            lb_r          <= PTR_ZERO;
            match_count_r <= PTR_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        la_r          <= len_a;
                        lb_r          <= len_b;
                        pa_r          <= PTR_ZERO;
                        pb_r          <= PTR_ZERO;
                        match_count_r <= PTR_ZERO;
                        if (len_zero_s) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    state_r <= ST_CMP;
                end
                ST_CMP: begin
                    if (idx_lt_s) begin
                        pa_r    <= pa_inc_s;
                        state_r <= a_last_s ? ST_DONE : ST_FETCH;
                    end else if (idx_gt_s) begin
                        pb_r    <= pb_inc_s;
                        state_r <= b_last_s ? ST_DONE : ST_FETCH;
                    end else if (!fifo_full) begin
                        // Equal and the FIFO accepts: both pointers advance
                        // on the edge that captures the write.
                        pa_r          <= pa_inc_s;
                        pb_r          <= pb_inc_s;
                        match_count_r <= match_count_r + PTR_ONE;
                        state_r       <= (a_last_s || b_last_s) ? ST_DONE : ST_FETCH;
                    end else begin
                        // Equal but FIFO full: hold everything; memory data
                        // stays valid because no new read is issued.
                        state_r <= ST_CMP;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from the state register; the match bus reads zero
    // whenever no write is being issued.
    always_comb begin
        a_rd        = (state_r == ST_FETCH);
        b_rd        = (state_r == ST_FETCH);
        a_addr      = pa_r[ADDR_W-1:0];
        b_addr      = pb_r[ADDR_W-1:0];
        busy        = (state_r == ST_FETCH) || (state_r == ST_CMP);
        done        = (state_r == ST_DONE);
        match_count = match_count_r;
        match_wr    = match_fire_s;
        if (match_fire_s) begin
            match_idx   = a_idx;
            match_a_pos = pa_r[ADDR_W-1:0];
            match_b_pos = pb_r[ADDR_W-1:0];
        end else begin
            match_idx   = IDX_ZERO;
            match_a_pos = ADDR_ZERO;
            match_b_pos = ADDR_ZERO;
        end
    end

endmodule

// File: tb/tb_pic_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pic_sequencer
//
// Scoreboard bench for pic_sequencer. Each run computes the expected matches
// (set intersection of the two lists), their cycles and the run length from
// the list contents, queues the matches, and a monitor pops and compares each
// FIFO write as it appears. Index memories are modelled as synchronous RAMs.
// ---------------------------------------------------------------------------
module tb_pic_sequencer;

    localparam int IDX_W  = 16;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W:0]   len_a;
    logic [ADDR_W:0]   len_b;
    logic              a_rd;
    logic [ADDR_W-1:0] a_addr;
    logic [IDX_W-1:0]  a_idx = '0;
    logic              b_rd;
    logic [ADDR_W-1:0] b_addr;
    logic [IDX_W-1:0]  b_idx = '0;
    logic              fifo_full;
    logic              match_wr;
    logic [IDX_W-1:0]  match_idx;
    logic [ADDR_W-1:0] match_a_pos;
    logic [ADDR_W-1:0] match_b_pos;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   match_count;

    pic_sequencer #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len_a(len_a), .len_b(len_b),
        .a_rd(a_rd), .a_addr(a_addr), .a_idx(a_idx),
        .b_rd(b_rd), .b_addr(b_addr), .b_idx(b_idx),
        .fifo_full(fifo_full), .match_wr(match_wr), .match_idx(match_idx),
        .match_a_pos(match_a_pos), .match_b_pos(match_b_pos),
        .busy(busy), .done(done), .match_count(match_count)
    );

    always #5 clk = ~clk;

    logic [IDX_W-1:0] mem_a [DEPTH];
    logic [IDX_W-1:0] mem_b [DEPTH];

    // Synchronous index memories: data follows a read by one cycle and holds.
    always @(posedge clk) begin
        if (a_rd) a_idx <= mem_a[a_addr];
        if (b_rd) b_idx <= mem_b[b_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [IDX_W-1:0]  idx;
        logic [ADDR_W-1:0] apos;
        logic [ADDR_W-1:0] bpos;
        int                cyc;
    } exp_t;
    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;
    bit sim_end = 1'b0;
    bit run_active = 1'b0;
    int t0 = 0;
    int la_cur = 0, lb_cur = 0;
    int stall_mode = 0, stall_lo = 0, stall_hi = 0;
    int rd_cnt = 0, viol = 0, done_cnt = 0, done_cyc = -1;
    logic busy_at_done = 1'b0;
    int fci;
    int mci;

    // FIFO back-pressure generator, driven early in each cycle.
    always @(posedge clk) begin
        #2;
        if (run_active) begin
            fci = cyc - t0 + 1;
            case (stall_mode)
                1:       fifo_full = (fci >= stall_lo) && (fci <= stall_hi);
                2:       fifo_full = ($urandom_range(0, 2) == 0);
                default: fifo_full = 1'b0;
            endcase
        end else begin
            fifo_full = 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_quiet_outputs(input string tag);
        check({tag, "_ctl"}, {28'd0, a_rd, b_rd, match_wr, busy, done, a_addr, b_addr, match_count}, 64'd0);
        check({tag, "_bus"}, {28'd0, match_idx, match_a_pos, match_b_pos}, 64'd0);
    endtask

    // One run: reference computation, stimulus, bounded wait, end checks.
    task automatic run_case(input string name, input int na, input int nb,
                            input int smode, input int slo, input int shi,
                            input bit mid_start);
        int m, k, c, ncmp, pa_f, pb_f, exp_done, w, nstall;
        logic [IDX_W-1:0] last;
        exp_t e;
        nstall = (smode == 1) ? (shi - slo + 1) : 0;
        m = 0;
        for (int i = 0; i < na; i++) begin
            for (int j = 0; j < nb; j++) begin
                if (mem_a[i] == mem_b[j]) begin
                    k = i + j - m + 1;   // comparisons up to and including this one
                    c = 2 * k;
                    if (smode == 1 && c >= slo) c = c + nstall;
                    if (smode == 2) c = -1;
                    e.idx = mem_a[i]; e.apos = i[ADDR_W-1:0]; e.bpos = j[ADDR_W-1:0]; e.cyc = c;
                    exp_q.push_back(e);
                    m++;
                end
            end
        end
        if (na == 0 || nb == 0) begin
            ncmp = 0;
            exp_done = 1;
        end else begin
            // The run ends once the list whose last entry is smaller is used up.
            last = (mem_a[na-1] < mem_b[nb-1]) ? mem_a[na-1] : mem_b[nb-1];
            pa_f = 0; pb_f = 0;
            for (int i = 0; i < na; i++) if (mem_a[i] <= last) pa_f++;
            for (int j = 0; j < nb; j++) if (mem_b[j] <= last) pb_f++;
            ncmp = pa_f + pb_f - m;
            exp_done = 2 * ncmp + 1 + nstall;
        end

        @(negedge clk);
        start = 1'b1; len_a = na[ADDR_W:0]; len_b = nb[ADDR_W:0];
        la_cur = na; lb_cur = nb;
        stall_mode = smode; stall_lo = slo; stall_hi = shi;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
        rd_cnt = 0; viol = 0; done_cnt = 0; done_cyc = -1;
        run_active = 1'b1;
        if (mid_start && ncmp >= 3 && smode == 0) begin
            repeat (3) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        w = 0;
        while (done_cnt == 0 && w < 5000) begin
            @(posedge clk);
            w++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({name, "_done_pulses"}, done_cnt, 1);
        if (smode != 2) check({name, "_done_cycle"}, done_cyc, exp_done);
        check({name, "_match_count"}, match_count, m);
        check({name, "_busy_at_done"}, busy_at_done, 1'b0);
        check({name, "_reads"}, rd_cnt, ncmp);
        check({name, "_rule_violations"}, viol, 0);
        check({name, "_leftover_matches"}, exp_q.size(), 0);
        check({name, "_busy_after"}, busy, 1'b0);
        exp_q.delete();
        run_active = 1'b0;
        stall_mode = 0;
    endtask

    task automatic load4(input int a0, input int a1, input int a2, input int a3,
                         input int b0, input int b1, input int b2, input int b3);
        mem_a[0] = a0[IDX_W-1:0]; mem_a[1] = a1[IDX_W-1:0];
        mem_a[2] = a2[IDX_W-1:0]; mem_a[3] = a3[IDX_W-1:0];
        mem_b[0] = b0[IDX_W-1:0]; mem_b[1] = b1[IDX_W-1:0];
        mem_b[2] = b2[IDX_W-1:0]; mem_b[3] = b3[IDX_W-1:0];
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len_a = '0; len_b = '0; fifo_full = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        fork
            // Monitor: pops the scoreboard on every FIFO write, tracks reads.
            begin
                while (!sim_end) begin
                    @(negedge clk);
                    if (run_active) begin
                        mci = cyc - t0 + 1;
                        if (a_rd) rd_cnt++;
                        if ((a_rd && int'(a_addr) >= la_cur) || (b_rd && int'(b_addr) >= lb_cur)) viol++;
                        if (a_rd != b_rd) viol++;
                        if (!match_wr && (match_idx != '0 || match_a_pos != '0 || match_b_pos != '0)) viol++;
                        if (match_wr) begin
                            if (exp_q.size() == 0) begin
                                check("match_unexpected", match_wr, 1'b0);
                            end else begin
                                exp_t e;
                                e = exp_q.pop_front();
                                check("match_fields", {match_idx, match_a_pos, match_b_pos},
                                      {e.idx, e.apos, e.bpos});
                                if (e.cyc >= 0) check("match_cycle", mci, e.cyc);
                            end
                        end
                        if (done) begin
                            done_cnt++;
                            done_cyc = mci;
                            busy_at_done = busy;
                        end
                    end
                end
            end
            // Stimulus sequence.
            begin
                #3;
                check_quiet_outputs("reset_state");
                @(negedge clk); @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check_quiet_outputs("idle_after_reset");

                load4(1, 3, 5, 7, 3, 4, 7, 9);
                run_case("basic", 4, 4, 0, 0, 0, 1'b0);

                run_case("empty_a", 0, 5, 0, 0, 0, 1'b0);

                load4(2, 4, 6, 8, 2, 4, 6, 8);
                run_case("identical", 4, 4, 0, 0, 0, 1'b0);

                load4(1, 3, 5, 7, 3, 4, 7, 9);
                run_case("stall3", 4, 4, 1, 4, 6, 1'b0);

                mem_a[0] = 16'h0000; mem_a[1] = 16'h0002;
                mem_b[0] = 16'h0001; mem_b[1] = 16'hFFFF;
                run_case("unsigned", 2, 2, 0, 0, 0, 1'b0);

                // Reset in cycle 3 of a run aborts it without a done pulse.
                load4(1, 3, 5, 7, 3, 4, 7, 9);
                @(negedge clk);
                start = 1'b1; len_a = 11'd4; len_b = 11'd4; la_cur = 4; lb_cur = 4;
                @(posedge clk);
                #1 start = 1'b0;
                t0 = cyc; done_cnt = 0; rd_cnt = 0; viol = 0;
                run_active = 1'b1;
                @(posedge clk); #1;
                @(posedge clk); #1;
                rst_n = 1'b0;
                #1;
                check_quiet_outputs("mid_run_reset");
                @(negedge clk); @(negedge clk);
                rst_n = 1'b1;
                repeat (6) @(posedge clk);
                #1;
                check("reset_no_done", done_cnt, 0);
                check("reset_no_match", match_count, 0);
                run_active = 1'b0;
                exp_q.delete();

                // Same stimulus after the abort, with a stray start mid-run.
                run_case("after_reset_midstart", 4, 4, 0, 0, 0, 1'b1);

                for (int r = 0; r < 24; r++) begin
                    int na, nb, v;
                    na = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 24);
                    nb = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 24);
                    v = ($urandom_range(0, 1) == 0) ? 0 : 16'hFF00;
                    v = v + $urandom_range(0, 3);
                    for (int i = 0; i < na; i++) begin
                        mem_a[i] = v[IDX_W-1:0];
                        v = v + $urandom_range(1, 3);
                    end
                    v = (v >= 16'hFF00) ? 16'hFF00 + $urandom_range(0, 3) : $urandom_range(0, 3);
                    for (int j = 0; j < nb; j++) begin
                        mem_b[j] = v[IDX_W-1:0];
                        v = v + $urandom_range(1, 3);
                    end
                    run_case($sformatf("rand%0d", r), na, nb, (r % 2 == 0) ? 0 : 2, 0, 0, (r % 3 == 0));
                end

                sim_end = 1'b1;
            end
        join
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
